// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache request queue: packed entry layout
// {wrreq, rdreq, be, addr, data} and word-address helper.
package dcache_pkg;

    function automatic int entry_bits(int databits, int addrbits);
        return databits + addrbits + databits / 8 + 2;
    endfunction

    function automatic int addr_lo(int databits);
        return databits;
    endfunction

    function automatic int be_lo(int databits, int addrbits);
        return databits + addrbits;
    endfunction

    function automatic int rdreq_bit(int databits, int addrbits);
        return databits + addrbits + databits / 8;
    endfunction

    function automatic int wrreq_bit(int databits, int addrbits);
        return databits + addrbits + databits / 8 + 1;
    endfunction

    // Lowest address bit that selects a data word rather than a byte in it.
    function automatic int word_lsb(int bebits);
        return $clog2(bebits);
    endfunction

endpackage

// File: rtl/dcache_reqqueue_if.sv
// Request-queue bundle: the dcache controller side is master, the queue is slave.
interface dcache_reqqueue_if #(
    parameter int DATABITS  = 32,
    parameter int ADDRBITS  = 32,
    parameter int DEPTHBITS = 3
);
    localparam int BEBITS = DATABITS / 8;

    logic [DATABITS-1:0]  in_data;
    logic [ADDRBITS-1:0]  in_addr;
    logic [BEBITS-1:0]    in_be;
    logic                 in_rdreq;
    logic                 in_wrreq;
    logic                 push;
    logic                 pop;
    logic                 flush;
    logic                 out_valid;
    logic [DATABITS-1:0]  out_data;
    logic [ADDRBITS-1:0]  out_addr;
    logic [BEBITS-1:0]    out_be;
    logic                 out_rdreq;
    logic                 out_wrreq;
    logic                 full;
    logic                 almost_full;
    logic [DEPTHBITS:0]   level;
    logic                 overflow;
    logic                 underflow;
    logic [ADDRBITS-1:0]  lookup_addr;
    logic                 lookup_hit;
    logic [DATABITS-1:0]  lookup_data;
    logic [BEBITS-1:0]    lookup_be;

    modport master (
        output in_data, in_addr, in_be, in_rdreq, in_wrreq, push, pop, flush, lookup_addr,
        input  out_valid, out_data, out_addr, out_be, out_rdreq, out_wrreq,
               full, almost_full, level, overflow, underflow,
               lookup_hit, lookup_data, lookup_be
    );

    modport slave (
        input  in_data, in_addr, in_be, in_rdreq, in_wrreq, push, pop, flush, lookup_addr,
        output out_valid, out_data, out_addr, out_be, out_rdreq, out_wrreq,
               full, almost_full, level, overflow, underflow,
               lookup_hit, lookup_data, lookup_be
    );

endinterface

// File: rtl/dcache_reqqueue_match.sv
// DEPTH-way word-address comparator over queued writes; the youngest match
// (closest to the write pointer) supplies data and byte enables.
module dcache_reqqueue_match
    import dcache_pkg::*;
#(
    parameter int DATABITS  = 32,
    parameter int ADDRBITS  = 32,
    parameter int DEPTHBITS = 3
) (
    input  logic [(2**DEPTHBITS)-1:0][entry_bits(DATABITS, ADDRBITS)-1:0] entries,
    input  logic [(2**DEPTHBITS)-1:0]  valid,
    input  logic [DEPTHBITS-1:0]       rd_ptr,
    input  logic [ADDRBITS-1:0]        lookup_addr,
    output logic                       hit,
    output logic [DATABITS-1:0]        data,
    output logic [DATABITS/8-1:0]      be
);
    localparam int DEPTH   = 2**DEPTHBITS;
    localparam int BEBITS  = DATABITS / 8;
    localparam int ADDR_LO = addr_lo(DATABITS);
    localparam int BE_LO   = be_lo(DATABITS, ADDRBITS);
    localparam int WR_BIT  = wrreq_bit(DATABITS, ADDRBITS);
    localparam int WL      = word_lsb(BEBITS);

    logic [DEPTHBITS-1:0] slot;
    logic                 unused_entries;
    logic                 unused_addr;

    // Byte-offset and read-flag bits take no part in the comparison.
    assign unused_entries = ^entries;
    assign unused_addr    = ^lookup_addr;

    // Walk oldest to youngest so the last match found wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        be   = '0;
        slot = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr + DEPTHBITS'(k);
            if (valid[slot] && entries[slot][WR_BIT] &&
                entries[slot][ADDR_LO+ADDRBITS-1:ADDR_LO+WL] == lookup_addr[ADDRBITS-1:WL]) begin
                hit  = 1'b1;
                data = entries[slot][DATABITS-1:0];
                be   = entries[slot][BE_LO +: BEBITS];
            end
        end
    end

endmodule

// File: rtl/dcache_reqqueue.sv
// First-word-fall-through request queue between the dcache controller and the
// fill/writeback engine, with sticky error flags, flush and store-hazard lookup.
module dcache_reqqueue
    import dcache_pkg::*;
#(
    parameter int DATABITS    = 32,
    parameter int ADDRBITS    = 32,
    parameter int DEPTHBITS   = 3,
    parameter int AFULL_LEVEL = (2**DEPTHBITS) - 2
) (
    input  logic             clk,
    input  logic             reset_n,
    dcache_reqqueue_if.slave q
);
    localparam int DEPTH   = 2**DEPTHBITS;
    localparam int BEBITS  = DATABITS / 8;
    localparam int EW      = entry_bits(DATABITS, ADDRBITS);
    localparam int ADDR_LO = addr_lo(DATABITS);
    localparam int BE_LO   = be_lo(DATABITS, ADDRBITS);
    localparam int RD_BIT  = rdreq_bit(DATABITS, ADDRBITS);
    localparam int WR_BIT  = wrreq_bit(DATABITS, ADDRBITS);

    logic [DEPTH-1:0][EW-1:0] mem;
    logic [DEPTHBITS:0]       wr_ptr;
    logic [DEPTHBITS:0]       rd_ptr;
    logic [DEPTHBITS:0]       level;
    logic                     empty;
    logic                     full;
    logic                     do_push;
    logic                     do_pop;
    logic                     overflow_r;
    logic                     underflow_r;
    logic [EW-1:0]            head;
    logic [DEPTH-1:0]         valid_mask;
    logic [DEPTHBITS-1:0]     offset;

    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTHBITS-1:0] == rd_ptr[DEPTHBITS-1:0]) &&
                   (wr_ptr[DEPTHBITS] != rd_ptr[DEPTHBITS]);

    // A push into a full queue succeeds when the head is leaving in the same cycle.
    assign do_pop  = q.pop && !empty;
    assign do_push = q.push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (q.flush) begin
            rd_ptr      <= wr_ptr;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (q.push && !do_push)
                overflow_r <= 1'b1;
            if (q.pop && empty)
                underflow_r <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !q.flush)
            mem[wr_ptr[DEPTHBITS-1:0]] <= {q.in_wrreq, q.in_rdreq, q.in_be, q.in_addr, q.in_data};
    end

    assign head          = mem[rd_ptr[DEPTHBITS-1:0]];
    assign q.out_valid   = !empty;
    assign q.out_data    = empty ? '0 : head[DATABITS-1:0];
    assign q.out_addr    = empty ? '0 : head[ADDR_LO +: ADDRBITS];
    assign q.out_be      = empty ? '0 : head[BE_LO +: BEBITS];
    assign q.out_rdreq   = !empty && head[RD_BIT];
    assign q.out_wrreq   = !empty && head[WR_BIT];
    assign q.full        = full;
    assign q.almost_full = int'(level) >= AFULL_LEVEL;
    assign q.level       = level;
    assign q.overflow    = overflow_r;
    assign q.underflow   = underflow_r;

    // A slot is live when its distance from the read pointer is below the level.
    always_comb begin
        valid_mask = '0;
        offset     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset        = DEPTHBITS'(i) - rd_ptr[DEPTHBITS-1:0];
            valid_mask[i] = {1'b0, offset} < level;
        end
    end

    dcache_reqqueue_match #(
        .DATABITS  (DATABITS),
        .ADDRBITS  (ADDRBITS),
        .DEPTHBITS (DEPTHBITS)
    ) u_match (
        .entries     (mem),
        .valid       (valid_mask),
        .rd_ptr      (rd_ptr[DEPTHBITS-1:0]),
        .lookup_addr (q.lookup_addr),
        .hit         (q.lookup_hit),
        .data        (q.lookup_data),
        .be          (q.lookup_be)
    );

endmodule

// File: tb/tb_dcache_reqqueue.sv
// Directed bench for dcache_reqqueue: status, FWFT order, wrap, lookup, flush, reset.
module tb_dcache_reqqueue;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    dcache_reqqueue_if #(.DATABITS(32), .ADDRBITS(32), .DEPTHBITS(3)) q ();

    dcache_reqqueue #(.DATABITS(32), .ADDRBITS(32), .DEPTHBITS(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input logic rd, input logic wr);
        q.in_addr  = addr;
        q.in_data  = data;
        q.in_be    = be;
        q.in_rdreq = rd;
        q.in_wrreq = wr;
        q.push     = 1'b1;
        step();
        q.push     = 1'b0;
    endtask

    task automatic do_pop();
        q.pop = 1'b1;
        step();
        q.pop = 1'b0;
    endtask

    task automatic do_flush();
        q.flush = 1'b1;
        step();
        q.flush = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        if ({q.out_valid, q.full, q.almost_full, q.overflow, q.underflow, q.level} !== 9'd0) begin
            $display("FAIL reset_status: got %b want 0", {q.out_valid, q.full, q.almost_full, q.overflow, q.underflow, q.level});
            n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        do_push(32'h100, 32'hA, 4'hF, 1'b0, 1'b1);
        do_push(32'h104, 32'hB, 4'hF, 1'b0, 1'b1);
        do_push(32'h108, 32'hC, 4'hF, 1'b0, 1'b1);
        if (q.level !== 4'd3) begin
            $display("FAIL basic_level: got %0d want 3", q.level); n_bad++;
        end
        n_cmp++;
        if (q.out_addr !== 32'h100 || q.out_data !== 32'hA || q.out_wrreq !== 1'b1) begin
            $display("FAIL basic_head0: got addr %h data %h wr %b want 100 a 1", q.out_addr, q.out_data, q.out_wrreq); n_bad++;
        end
        n_cmp++;
        do_pop();
        if (q.out_addr !== 32'h104 || q.out_data !== 32'hB) begin
            $display("FAIL basic_head1: got addr %h data %h want 104 b", q.out_addr, q.out_data); n_bad++;
        end
        n_cmp++;
        do_pop();
        do_pop();
        if ({q.out_valid, q.out_data, q.out_addr, q.out_be, q.out_rdreq, q.out_wrreq} !== 71'd0) begin
            $display("FAIL basic_empty_out: got valid %b data %h addr %h be %h rd %b wr %b want all 0",
                     q.out_valid, q.out_data, q.out_addr, q.out_be, q.out_rdreq, q.out_wrreq); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 8; i++) begin
            do_push(32'h1000 + 32'(i * 4), 32'h50 + 32'(i), 4'hF, 1'b0, 1'b1);
            if (q.almost_full !== (i + 1 >= 6)) begin
                $display("FAIL fill_afull_%0d: got %b want %b", i + 1, q.almost_full, (i + 1 >= 6)); n_bad++;
            end
            n_cmp++;
        end
        if (q.full !== 1'b1 || q.level !== 4'd8 || q.overflow !== 1'b0) begin
            $display("FAIL fill_full: got full %b level %0d ovf %b want 1 8 0", q.full, q.level, q.overflow); n_bad++;
        end
        n_cmp++;
        do_push(32'h2000, 32'hDEAD, 4'hF, 1'b0, 1'b1);
        if (q.full !== 1'b1 || q.level !== 4'd8 || q.overflow !== 1'b1) begin
            $display("FAIL fill_overflow: got full %b level %0d ovf %b want 1 8 1", q.full, q.level, q.overflow); n_bad++;
        end
        n_cmp++;
        for (int i = 0; i < 8; i++) begin
            if (q.out_data !== 32'h50 + 32'(i)) begin
                $display("FAIL fill_order_%0d: got %h want %h", i, q.out_data, 32'h50 + 32'(i)); n_bad++;
            end
            n_cmp++;
            do_pop();
        end
        if (q.out_valid !== 1'b0 || q.overflow !== 1'b1) begin
            $display("FAIL fill_drained: got valid %b ovf %b want 0 1", q.out_valid, q.overflow); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        do_flush();
        if (q.overflow !== 1'b0) begin
            $display("FAIL b2b_flush_ovf: got %b want 0", q.overflow); n_bad++;
        end
        n_cmp++;
        for (int i = 0; i < 8; i++)
            do_push(32'h3000 + 32'(i * 4), 32'h200 + 32'(i), 4'hF, 1'b0, 1'b1);
        q.pop = 1'b1;
        do_push(32'h4000, 32'h300, 4'hF, 1'b0, 1'b1);
        q.pop = 1'b0;
        if (q.level !== 4'd8 || q.full !== 1'b1 || q.overflow !== 1'b0 || q.out_data !== 32'h201) begin
            $display("FAIL b2b_full_pushpop: got level %0d full %b ovf %b head %h want 8 1 0 201",
                     q.level, q.full, q.overflow, q.out_data); n_bad++;
        end
        n_cmp++;
        for (int j = 1; j <= 20; j++) begin
            exp = (j < 8) ? 32'h200 + 32'(j) : 32'h300 + 32'(j - 8);
            if (q.out_data !== exp) begin
                $display("FAIL b2b_order_%0d: got %h want %h", j, q.out_data, exp); n_bad++;
            end
            n_cmp++;
            q.pop = 1'b1;
            do_push(32'h4000 + 32'(j * 4), 32'h300 + 32'(j), 4'hF, 1'b0, 1'b1);
            q.pop = 1'b0;
        end
        if (q.level !== 4'd8 || q.overflow !== 1'b0) begin
            $display("FAIL b2b_level: got level %0d ovf %b want 8 0", q.level, q.overflow); n_bad++;
        end
        n_cmp++;
        for (int j = 21; j < 29; j++) begin
            exp = 32'h300 + 32'(j - 8);
            if (q.out_data !== exp) begin
                $display("FAIL b2b_drain_%0d: got %h want %h", j, q.out_data, exp); n_bad++;
            end
            n_cmp++;
            do_pop();
        end
        if (q.out_valid !== 1'b0) begin
            $display("FAIL b2b_empty: got valid %b want 0", q.out_valid); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_lookup();
        do_push(32'h200, 32'h11, 4'h3, 1'b0, 1'b1);
        do_push(32'h204, 32'h22, 4'hF, 1'b0, 1'b1);
        do_push(32'h200, 32'h33, 4'hC, 1'b0, 1'b1);
        q.lookup_addr = 32'h202;
        #1;
        if (q.lookup_hit !== 1'b1 || q.lookup_data !== 32'h33 || q.lookup_be !== 4'hC) begin
            $display("FAIL lookup_youngest: got hit %b data %h be %h want 1 33 c", q.lookup_hit, q.lookup_data, q.lookup_be); n_bad++;
        end
        n_cmp++;
        q.lookup_addr = 32'h300;
        #1;
        if (q.lookup_hit !== 1'b0 || q.lookup_data !== 32'h0 || q.lookup_be !== 4'h0) begin
            $display("FAIL lookup_miss: got hit %b data %h be %h want 0 0 0", q.lookup_hit, q.lookup_data, q.lookup_be); n_bad++;
        end
        n_cmp++;
        q.lookup_addr = 32'h207;
        #1;
        if (q.lookup_hit !== 1'b1 || q.lookup_data !== 32'h22 || q.lookup_be !== 4'hF) begin
            $display("FAIL lookup_other: got hit %b data %h be %h want 1 22 f", q.lookup_hit, q.lookup_data, q.lookup_be); n_bad++;
        end
        n_cmp++;
        do_pop();
        do_pop();
        do_pop();
        do_push(32'h200, 32'h99, 4'h0, 1'b1, 1'b0);
        q.lookup_addr = 32'h200;
        #1;
        if (q.lookup_hit !== 1'b0 || q.out_rdreq !== 1'b1) begin
            $display("FAIL lookup_read_only: got hit %b rdreq %b want 0 1", q.lookup_hit, q.out_rdreq); n_bad++;
        end
        n_cmp++;
        do_pop();
        q.lookup_addr = 32'h400;
        q.in_addr  = 32'h400;
        q.in_data  = 32'h44;
        q.in_be    = 4'hF;
        q.in_rdreq = 1'b0;
        q.in_wrreq = 1'b1;
        q.push     = 1'b1;
        #1;
        if (q.lookup_hit !== 1'b0) begin
            $display("FAIL lookup_pushing: got hit %b want 0", q.lookup_hit); n_bad++;
        end
        n_cmp++;
        step();
        q.push = 1'b0;
        if (q.lookup_hit !== 1'b1 || q.lookup_data !== 32'h44) begin
            $display("FAIL lookup_pushed: got hit %b data %h want 1 44", q.lookup_hit, q.lookup_data); n_bad++;
        end
        n_cmp++;
        q.pop = 1'b1;
        #1;
        if (q.lookup_hit !== 1'b1) begin
            $display("FAIL lookup_popping: got hit %b want 1", q.lookup_hit); n_bad++;
        end
        n_cmp++;
        step();
        q.pop = 1'b0;
        if (q.lookup_hit !== 1'b0) begin
            $display("FAIL lookup_popped: got hit %b want 0", q.lookup_hit); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_underflow_flush();
        do_pop();
        if (q.underflow !== 1'b1 || q.level !== 4'd0 || q.out_valid !== 1'b0) begin
            $display("FAIL uf_set: got uf %b level %0d valid %b want 1 0 0", q.underflow, q.level, q.out_valid); n_bad++;
        end
        n_cmp++;
        do_push(32'h500, 32'h77, 4'hF, 1'b0, 1'b1);
        if (q.level !== 4'd1 || q.out_data !== 32'h77) begin
            $display("FAIL uf_ptrs: got level %0d head %h want 1 77", q.level, q.out_data); n_bad++;
        end
        n_cmp++;
        for (int i = 0; i < 3; i++)
            do_push(32'h504 + 32'(i * 4), 32'h78 + 32'(i), 4'hF, 1'b0, 1'b1);
        if (q.level !== 4'd4) begin
            $display("FAIL flush_pre_level: got %0d want 4", q.level); n_bad++;
        end
        n_cmp++;
        q.flush = 1'b1;
        do_push(32'h600, 32'hEE, 4'hF, 1'b0, 1'b1);
        q.flush = 1'b0;
        if (q.level !== 4'd0 || q.out_valid !== 1'b0 || q.underflow !== 1'b0) begin
            $display("FAIL flush_clear: got level %0d valid %b uf %b want 0 0 0", q.level, q.out_valid, q.underflow); n_bad++;
        end
        n_cmp++;
        step();
        if (q.level !== 4'd0 || q.out_data !== 32'h0) begin
            $display("FAIL flush_push_dropped: got level %0d data %h want 0 0", q.level, q.out_data); n_bad++;
        end
        n_cmp++;
        q.pop = 1'b1;
        do_push(32'h700, 32'h55, 4'hF, 1'b0, 1'b1);
        q.pop = 1'b0;
        if (q.level !== 4'd1 || q.underflow !== 1'b1 || q.out_data !== 32'h55) begin
            $display("FAIL empty_pushpop: got level %0d uf %b head %h want 1 1 55", q.level, q.underflow, q.out_data); n_bad++;
        end
        n_cmp++;
        do_flush();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++)
            do_push(32'h800 + 32'(i * 4), 32'h90 + 32'(i), 4'hF, 1'b0, 1'b1);
        do_pop();
        do_pop();
        do_pop();
        do_pop();
        do_pop();
        do_pop();
        for (int i = 0; i < 5; i++)
            do_push(32'h800 + 32'(i * 4), 32'h90 + 32'(i), 4'hF, 1'b0, 1'b1);
        if (q.level !== 4'd5 || q.underflow !== 1'b1) begin
            $display("FAIL areset_pre: got level %0d uf %b want 5 1", q.level, q.underflow); n_bad++;
        end
        n_cmp++;
        #2;
        reset_n = 1'b0;
        #1;
        if ({q.out_valid, q.full, q.almost_full, q.overflow, q.underflow, q.level} !== 9'd0) begin
            $display("FAIL areset_immediate: got %b want 0", {q.out_valid, q.full, q.almost_full, q.overflow, q.underflow, q.level}); n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        reset_n = 1'b1;
        do_push(32'hABC0, 32'hABC, 4'h5, 1'b0, 1'b1);
        if (q.out_valid !== 1'b1 || q.out_data !== 32'hABC || q.out_be !== 4'h5 || q.level !== 4'd1) begin
            $display("FAIL areset_first_push: got valid %b data %h be %h level %0d want 1 abc 5 1",
                     q.out_valid, q.out_data, q.out_be, q.level); n_bad++;
        end
        n_cmp++;
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        reset_n       = 1'b0;
        q.in_data     = '0;
        q.in_addr     = '0;
        q.in_be       = '0;
        q.in_rdreq    = 1'b0;
        q.in_wrreq    = 1'b0;
        q.push        = 1'b0;
        q.pop         = 1'b0;
        q.flush       = 1'b0;
        q.lookup_addr = '0;
        test_reset();
        test_basic();
        test_fill_overflow();
        test_back_to_back();
        test_lookup();
        test_underflow_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_reqqueue.md
Name: dcache_reqqueue

Overview:
Parametrised FIFO for data-cache memory requests, placed between the CPU-side dcache controller and the memory-side fill/writeback engine. It is the successor to the fixed 8-deep, 32/32-bit request queue.
- Adds byte enables, full/almost-full/level status and overflow/underflow protection.
- Adds synchronous flush.
- Adds a combinational pending-write lookup so loads can detect store hazards and forward data.

Parameters:
DATABITS, 32, data word width; must be a multiple of 8
ADDRBITS, 32, byte address width
DEPTHBITS, 3, log2 of queue depth; DEPTH=2**DEPTHBITS
AFULL_LEVEL, DEPTH-2, level at or above which almost_full asserts
BEBITS, DATABITS/8, byte-enable width (derived; do not override)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
in_data  input  DATABITS  write data
in_addr  input  ADDRBITS  request byte address
in_be  input  BEBITS  byte enables (writes only)
in_rdreq  input  1  entry is a read request
in_wrreq  input  1  entry is a write request
push  input  1  enqueue the in_* fields this cycle
pop  input  1  dequeue the head entry this cycle
flush  input  1  synchronous discard of all entries
out_valid  output  1  head entry valid (FWFT)
out_data  output  DATABITS  head data
out_addr  output  ADDRBITS  head address
out_be  output  BEBITS  head byte enables
out_rdreq  output  1  head read flag
out_wrreq  output  1  head write flag
full  output  1  level==DEPTH
almost_full  output  1  level>=AFULL_LEVEL
level  output  DEPTHBITS+1  current occupancy
overflow  output  1  sticky: push while full
underflow  output  1  sticky: pop while empty
lookup_addr  input  ADDRBITS  load address to check
lookup_hit  output  1  valid pending write to same word
lookup_data  output  DATABITS  data of youngest matching write
lookup_be  output  BEBITS  byte enables of youngest matching write

Behaviour:
- Pointers wr_ptr and rd_ptr are DEPTHBITS+1 bits wide; the MSB is the wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - level = wr_ptr - rd_ptr, modulo 2**(DEPTHBITS+1).
- Reset (async, reset_n=0): pointers=0, level=0, out_valid=0, full=0, almost_full=0, overflow=0, underflow=0. Memory contents are not reset.
- First-word fall-through: out_* reflect mem[rd_ptr] combinationally.
  - out_valid = !empty.
  - When empty, out_data/addr/be/rdreq/wrreq are forced to 0.
- Push writes {wrreq, rdreq, be, addr, data} at wr_ptr and increments wr_ptr on the clock edge. The entry is visible on out_* the next cycle (1-cycle latency when empty).
- Pop increments rd_ptr on the clock edge.
- Push while full is ignored: no write, no pointer change. overflow sets and stays set until reset or flush.
- Pop while empty is ignored: underflow sets and stays set until reset or flush.
- Simultaneous push and pop:
  - When neither full nor empty: both take effect; level is unchanged.
  - When full: the pop takes effect and the push is accepted too, because the slot being freed is written. Level stays DEPTH, no overflow.
  - When empty: the pop is ignored and underflow sets; the push takes effect and level becomes 1.
- Flush has priority over push and pop: rd_ptr := wr_ptr, overflow := 0, underflow := 0. The push in the same cycle is dropped.
- Pointer wrap is natural modulo arithmetic; no special case.
- Lookup (combinational, zero latency):
  - Compare lookup_addr[ADDRBITS-1:log2(BEBITS)] against every valid entry with wrreq=1.
  - Valid means slot index lies in [rd_ptr, wr_ptr) taking wrap into account.
  - lookup_hit=1 on any match. lookup_data/be come from the youngest match (closest to wr_ptr); otherwise lookup_data/be=0.
  - Entries being pushed this cycle are not visible. Entries being popped this cycle are still visible.
- An entry with both rdreq and wrreq=0 is stored and passed through unchanged; it never produces a lookup hit.

Decomposition:
- Shared package dcache_pkg:
  - entry field offsets and the packed entry width (DATABITS+ADDRBITS+BEBITS+2)
  - the function computing the word-address low bit log2(BEBITS)
- One sub-module: dcache_reqqueue_match, a DEPTH-way address comparator with a youngest-first priority select. Inputs: packed entries, valid mask, rd_ptr. Outputs: hit, data, be.

Test Plan:
- Reset, push 3 writes (addr 0x100/0x104/0x108, data 0xA/0xB/0xC, be 0xF) -> level=3, head addr 0x100 and data 0xA; after 3 pops, out_valid=0 and all out_* fields are 0.
- Fill 8 entries, push a 9th -> full=1, level=8, overflow=1, and the 9th entry never appears on out_*; almost_full=1 from level 6.
- Full queue with simultaneous push+pop -> level stays 8, no overflow, new entry emerges 8th after wrap; run 20 push/pop cycles to cross the pointer wrap twice with in-order data.
- Queue writes 0x200 be=0x3 data 0x11, then 0x204 data 0x22, then 0x200 be=0xC data 0x33; lookup 0x202 -> hit=1, data 0x33, be 0xC; lookup 0x300 -> hit=0; a read to 0x200 in the queue alone -> no hit.
- Pop on an empty queue -> underflow=1 and pointers unchanged; then flush with 4 entries queued -> level=0, out_valid=0, underflow=0, and the same-cycle push is dropped.
- Assert reset_n mid-stream with 5 entries queued -> all status outputs are 0 immediately (async); after release, first push appears at the head next cycle.
